// File: rtl/q2a03_bus_responder_if.sv
// CPU-side bus bundle for the 2A03 bus responder: the CPU drives the master side,
// the responder sits on the slave side.
interface q2a03_bus_responder_if;
  logic        G_phy2;
  logic [15:0] G_addr;
  logic        G_rdwr;
  logic [7:0]  G_wr_data;
  logic        G_sync;
  logic [7:0]  G_rd_data;
  logic        G_ready;
  logic        G_irq;

  modport master (
    output G_phy2,
    output G_addr,
    output G_rdwr,
    output G_wr_data,
    output G_sync,
    input  G_rd_data,
    input  G_ready,
    input  G_irq
  );

  modport slave (
    input  G_phy2,
    input  G_addr,
    input  G_rdwr,
    input  G_wr_data,
    input  G_sync,
    output G_rd_data,
    output G_ready,
    output G_irq
  );
endinterface

// File: rtl/q2a03_bus_responder.sv
// Bus responder for a 2A03-style CPU: mirrored RAM, timer/sync registers, wait-stated
// slow memory and an open-bus latch, all sequenced off detected phy2 edges.
module q2a03_bus_responder #(
  parameter int unsigned RAM_AW      = 11,
  parameter int unsigned SLOW_AW     = 15,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic                  G_clock,
  input logic                  G_reset,
  q2a03_bus_responder_if.slave bus
);

  localparam logic [3:0] WaitCnt = 4'(WAIT_STATES);
  localparam bit         HasWait = (WAIT_STATES != 0);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e state_q, state_d;

  logic               phy2_q;
  logic               rise, fall;
  logic [3:0]         wcnt_q, wcnt_d;
  logic [SLOW_AW-1:0] addr_q, addr_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic [7:0]         open_bus_q, open_bus_d;
  logic [7:0]         reload_lo_q, reload_lo_d;
  logic [7:0]         reload_hi_q, reload_hi_d;
  logic               irq_en_q, irq_en_d;
  logic               run_q, run_d;
  logic               irq_pending_q, irq_pending_d;
  logic [15:0]        timer_q, timer_d;
  logic [7:0]         sync_count_q, sync_count_d;
  logic               ready;

  logic [7:0] ram_mem  [2**RAM_AW];
  logic [7:0] slow_mem [2**SLOW_AW];

  logic       ram_hit, reg_hit, slow_hit, mapped;
  logic       wr_commit, ram_we, slow_we, reg_we;
  logic [7:0] reg_rdata, read_byte, done_rdata;
  logic       underflow;

  assign rise = bus.G_phy2 & ~phy2_q;
  assign fall = ~bus.G_phy2 & phy2_q;

  assign ram_hit  = (bus.G_addr[15:13] == 3'b000);
  assign reg_hit  = (bus.G_addr[15:2] == 14'h1008);
  assign slow_hit = bus.G_addr[15];
  assign mapped   = ram_hit | reg_hit | slow_hit;

  // Writes are only accepted outside a stalled read; a reset holds phy2_q low so no
  // fall (and hence no memory write) can be seen while G_reset is asserted.
  assign wr_commit = fall & (state_q == StIdle) & ~bus.G_rdwr;
  assign ram_we    = wr_commit & ram_hit;
  assign slow_we   = wr_commit & slow_hit;
  assign reg_we    = wr_commit & reg_hit;

  assign underflow = fall & run_q & (timer_q == 16'd0);

  always_comb begin
    reg_rdata = reload_lo_q;
    case (bus.G_addr[1:0])
      2'd0:    reg_rdata = reload_lo_q;
      2'd1:    reg_rdata = reload_hi_q;
      2'd2:    reg_rdata = {5'b0, irq_pending_q, run_q, irq_en_q};
      default: reg_rdata = sync_count_q;
    endcase
  end

  always_comb begin
    read_byte = open_bus_q;
    if (ram_hit) begin
      read_byte = ram_mem[bus.G_addr[RAM_AW-1:0]];
    end else if (reg_hit) begin
      read_byte = reg_rdata;
    end else if (slow_hit) begin
      read_byte = slow_mem[bus.G_addr[SLOW_AW-1:0]];
    end
  end

  assign done_rdata = slow_mem[addr_q];

  // ---------------------------------------------------------------------------
  // Wait FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      state_q <= StIdle;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      StIdle: begin
        if (HasWait && rise && bus.G_rdwr && slow_hit) begin
          state_d = StWait;
          wcnt_d  = WaitCnt;
        end
      end
      StWait: begin
        if (fall) begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (fall) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready = (state_q != StWait);
  end

  // ---------------------------------------------------------------------------
  // Datapath: read data, open bus, registers, timer, sync counter
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d        = addr_q;
    rd_data_d     = rd_data_q;
    open_bus_d    = open_bus_q;
    reload_lo_d   = reload_lo_q;
    reload_hi_d   = reload_hi_q;
    irq_en_d      = irq_en_q;
    run_d         = run_q;
    irq_pending_d = irq_pending_q;
    timer_d       = timer_q;
    sync_count_d  = sync_count_q;

    if (rise) begin
      if (state_q == StIdle && bus.G_rdwr) begin
        if (HasWait && slow_hit) begin
          // Data arrives on the rise seen in StDone, from the latched address.
          addr_d = bus.G_addr[SLOW_AW-1:0];
        end else if (mapped) begin
          rd_data_d  = read_byte;
          open_bus_d = read_byte;
        end else begin
          rd_data_d = open_bus_q;
        end
      end else if (state_q == StDone) begin
        rd_data_d  = done_rdata;
        open_bus_d = done_rdata;
      end
    end

    if (wr_commit) begin
      open_bus_d = bus.G_wr_data;
    end

    if (fall && run_q) begin
      timer_d = underflow ? {reload_hi_q, reload_lo_q} : timer_q - 16'd1;
    end

    if (fall && bus.G_sync) begin
      sync_count_d = sync_count_q + 8'd1;
    end

    if (reg_we) begin
      case (bus.G_addr[1:0])
        2'd0: reload_lo_d = bus.G_wr_data;
        2'd1: reload_hi_d = bus.G_wr_data;
        2'd2: begin
          irq_en_d      = bus.G_wr_data[0];
          run_d         = bus.G_wr_data[1];
          irq_pending_d = 1'b0;
          if (!run_q && bus.G_wr_data[1]) begin
            timer_d = {reload_hi_q, reload_lo_q};
          end
        end
        default: sync_count_d = 8'd0;
      endcase
    end

    // A same-edge underflow beats the clear from a control write.
    if (underflow) begin
      irq_pending_d = 1'b1;
    end
  end

  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      phy2_q        <= 1'b0;
      addr_q        <= '0;
      rd_data_q     <= 8'd0;
      open_bus_q    <= 8'd0;
      reload_lo_q   <= 8'd0;
      reload_hi_q   <= 8'd0;
      irq_en_q      <= 1'b0;
      run_q         <= 1'b0;
      irq_pending_q <= 1'b0;
      timer_q       <= 16'd0;
      sync_count_q  <= 8'd0;
    end else begin
      phy2_q        <= bus.G_phy2;
      addr_q        <= addr_d;
      rd_data_q     <= rd_data_d;
      open_bus_q    <= open_bus_d;
      reload_lo_q   <= reload_lo_d;
      reload_hi_q   <= reload_hi_d;
      irq_en_q      <= irq_en_d;
      run_q         <= run_d;
      irq_pending_q <= irq_pending_d;
      timer_q       <= timer_d;
      sync_count_q  <= sync_count_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge G_clock) begin
    if (ram_we) begin
      ram_mem[bus.G_addr[RAM_AW-1:0]] <= bus.G_wr_data;
    end
  end

  always_ff @(posedge G_clock) begin
    if (slow_we) begin
      slow_mem[bus.G_addr[SLOW_AW-1:0]] <= bus.G_wr_data;
    end
  end

  assign bus.G_rd_data = rd_data_q;
  assign bus.G_ready   = ready;
  assign bus.G_irq     = ~(irq_pending_q & irq_en_q);

endmodule

// File: doc/q2a03_bus_responder.md
Q2A03_BUS_RESPONDER -- requirements
Module: q2a03_bus_responder

Interface
REQ-001 The block SHALL have parameter RAM_AW, default 11, giving the internal RAM address width (2 KiB), mirrored across $0000-$1FFF.
REQ-002 The block SHALL have parameter SLOW_AW, default 15, giving the slow-memory address width, mapped at $8000-$FFFF.
REQ-003 The block SHALL have parameter WAIT_STATES, default 2, range 0-15, giving the extra CPU cycles per slow-memory read.
REQ-004 Reset SHALL be G_reset (asynchronous, active-low), and the clock SHALL be G_clock.
REQ-005 G_clock  input  1  system clock, same clock as the CPU core.
REQ-006 G_reset  input  1  asynchronous active-low reset.
REQ-007 G_phy2  input  1  CPU phase-2; the bus cycle is valid while high and ends on the falling edge.
REQ-008 G_addr  input  16  CPU address.
REQ-009 G_rdwr  input  1  1=read, 0=write.
REQ-010 G_wr_data  input  8  CPU write data.
REQ-011 G_sync  input  1  opcode-fetch cycle indicator.
REQ-012 G_rd_data  output  8  read data returned to the CPU.
REQ-013 G_ready  output  1  1=access completes this cycle, 0=stall.
REQ-014 G_irq  output  1  active-low interrupt request.

Function
REQ-015 All sequential logic SHALL run on posedge G_clock; phy2 rise and fall SHALL be detected by a registered copy of G_phy2, with each edge seen exactly once.
REQ-016 Decode SHALL be: $0000-$1FFF RAM (addr[RAM_AW-1:0]); $4020-$4023 registers; $8000-$FFFF slow memory (addr[SLOW_AW-1:0]); all other addresses unmapped.
REQ-017 Reads SHALL drive G_rd_data by the clock after phy2 rise and hold it stable until the next phy2 rise.
REQ-018 Writes SHALL commit on phy2 fall using the G_addr and G_wr_data present at that edge.
REQ-019 An unmapped read SHALL return the open-bus latch, defined as the last byte transferred in either direction.
REQ-020 Unmapped writes SHALL update only the open-bus latch.
REQ-021 Slow reads SHALL use the wait FSM with states IDLE, WAIT, DONE.
  - On phy2 rise of a slow read with WAIT_STATES>0: load wcnt=WAIT_STATES, clear G_ready, enter WAIT.
  - On each phy2 fall in WAIT: decrement wcnt; when wcnt reaches 0, set G_ready and enter DONE.
  - In DONE, the access completes at the next phy2 fall, then the FSM returns to IDLE.
  - With WAIT_STATES=0 the FSM SHALL stay in IDLE and G_ready SHALL stay 1.
REQ-022 During WAIT, G_addr changes SHALL be ignored, because the latched address is used.
REQ-023 Slow writes SHALL never stall (G_ready=1), and SHALL commit on phy2 fall.
REQ-024 Register map:
  - $4020 RW: timer reload low.
  - $4021 RW: timer reload high.
  - $4022 RW: control; bit0 irq_en, bit1 run. A write also clears irq_pending. A read returns {5'b0, irq_pending, run, irq_en}.
  - $4023 R: sync_count[7:0]; a write clears sync_count.
REQ-025 The timer SHALL be a 16-bit down-counter that decrements on each phy2 fall while run=1.
  - On reaching 0 it SHALL reload and set irq_pending, giving a period of reload+1 CPU cycles.
  - Writing run 0->1 SHALL load the counter from reload.
REQ-026 G_irq SHALL equal ~(irq_pending & irq_en).
REQ-027 If a timer underflow and a $4022 write occur on the same phy2 fall, the set SHALL win and irq_pending SHALL be 1.
REQ-028 sync_count SHALL be 8 bits, incremented on phy2 fall when G_sync=1, wrapping $FF->$00. A same-edge $4023 write SHALL win and leave 0.
REQ-029 When G_reset is deasserted and G_phy2 is static, no state SHALL change.

Reset
REQ-030 On G_reset low, the block SHALL immediately set:
  - G_rd_data=0, G_ready=1, G_irq=1;
  - FSM=IDLE, wcnt=0, timer reload and counter=0;
  - control=0, irq_pending=0, sync_count=0, open-bus=0.
REQ-031 A reset asserted during a write or a WAIT SHALL abort the access with no memory update.
REQ-032 RAM and slow-memory contents SHALL NOT be reset.

Verification
REQ-033 Write $5A to $0005, then read $0805 -> returns $5A (mirror), G_ready stays 1.
REQ-034 WAIT_STATES=2: write $C3 to $8123, then read $8123 -> G_ready low for exactly 2 phy2 periods, then $C3 is returned with G_ready=1.
REQ-035 Write $4020=$03, $4021=$00, $4022=$03 -> G_irq falls 4 CPU cycles after the run write; write $4022=$03 -> G_irq returns high and re-falls 4 cycles later.
REQ-036 Drive G_sync=1 for 257 phy2 periods -> $4023 reads $01; write $4023 -> reads $00.
REQ-037 Write $77 to $0000, then read $5000 -> returns $77 (open bus).
REQ-038 Assert G_reset mid-WAIT on a slow read -> G_ready=1 and G_irq=1 immediately; FSM is IDLE after release.
